// File: rtl/vga_pkg.sv
// vga_pkg: shared 1280x1024@60 raster constants and coordinate widths
package vga_pkg;
  localparam int COL_W = 12;
  localparam int ROW_W = 11;
  localparam int H_ACTIVE = 1280;
  localparam int H_FRONT = 48;
  localparam int H_SYNC = 112;
  localparam int H_BACK = 248;
  localparam int V_ACTIVE = 1024;
  localparam int V_FRONT = 1;
  localparam int V_SYNC = 3;
  localparam int V_BACK = 38;
  localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
  localparam int HS_START = H_ACTIVE + H_FRONT;
  localparam int HS_END = HS_START + H_SYNC;
  localparam int VS_START = V_ACTIVE + V_FRONT;
  localparam int VS_END = VS_START + V_SYNC;
  localparam logic SYNC_POL = 1'b1;
  localparam int SYNC_DELAY = 2;
endpackage

// File: rtl/vga_timing_if.sv
// vga_timing_if: pixel-coordinate stream and VGA sync outputs
interface vga_timing_if;
  import vga_pkg::*;
  logic [COL_W-1:0] display_col;
  logic [ROW_W-1:0] display_row;
  logic visible;
  logic frame_start;
  logic line_start;
  logic vga_hs;
  logic vga_vs;
  logic vga_de;
  modport master(output display_col, display_row, visible, frame_start, line_start, vga_hs, vga_vs, vga_de);
  modport slave(input display_col, display_row, visible, frame_start, line_start, vga_hs, vga_vs, vga_de);
endinterface

// File: rtl/sync_delay_line.sv
// sync_delay_line: W-bit, D-deep shift register with reset value; D=0 is a wire
module sync_delay_line #(
  parameter int W = 1,
  parameter int D = 1,
  parameter logic [W-1:0] RST = '0
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);
  if (D == 0) begin : g_pass
    assign q_o = d_i;
  end else begin : g_pipe
    logic [W-1:0] stage_q [D];
    // shift one stage per clock, all stages cleared to RST
    always_ff @(posedge clk_i or posedge rst_i)
      if (rst_i) begin
        for (int i = 0; i < D; i++) stage_q[i] <= RST;
      end else begin
        stage_q[0] <= d_i;
        for (int i = 1; i < D; i++) stage_q[i] <= stage_q[i-1];
      end
    assign q_o = stage_q[D-1];
  end
endmodule

// File: rtl/vga_timing.sv
// vga_timing: free-running raster counters with decode and delayed VGA syncs
module vga_timing #(
  parameter int H_ACTIVE = vga_pkg::H_ACTIVE,
  parameter int H_FRONT = vga_pkg::H_FRONT,
  parameter int H_SYNC = vga_pkg::H_SYNC,
  parameter int H_BACK = vga_pkg::H_BACK,
  parameter int V_ACTIVE = vga_pkg::V_ACTIVE,
  parameter int V_FRONT = vga_pkg::V_FRONT,
  parameter int V_SYNC = vga_pkg::V_SYNC,
  parameter int V_BACK = vga_pkg::V_BACK,
  parameter logic SYNC_POL = vga_pkg::SYNC_POL,
  parameter int SYNC_DELAY = vga_pkg::SYNC_DELAY
) (
  input logic          clk_i,
  input logic          rst_i,
  vga_timing_if.master vga
);
  localparam int CW = vga_pkg::COL_W;
  localparam int RW = vga_pkg::ROW_W;
  localparam logic [CW-1:0] H_LAST = CW'(H_ACTIVE + H_FRONT + H_SYNC + H_BACK - 1);
  localparam logic [CW-1:0] H_VIS = CW'(H_ACTIVE);
  localparam logic [CW-1:0] HS_START = CW'(H_ACTIVE + H_FRONT);
  localparam logic [CW-1:0] HS_END = CW'(H_ACTIVE + H_FRONT + H_SYNC);
  localparam logic [RW-1:0] V_LAST = RW'(V_ACTIVE + V_FRONT + V_SYNC + V_BACK - 1);
  localparam logic [RW-1:0] V_VIS = RW'(V_ACTIVE);
  localparam logic [RW-1:0] VS_START = RW'(V_ACTIVE + V_FRONT);
  localparam logic [RW-1:0] VS_END = RW'(V_ACTIVE + V_FRONT + V_SYNC);
  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;
  logic h_wrap, hs_raw, vs_raw, vis_raw;
  logic [2:0] dly_q;
  // next raster position: row only moves on the column wrap
  always_comb begin
    h_wrap = col_q == H_LAST;
    col_d = h_wrap ? '0 : col_q + 1'b1;
    row_d = !h_wrap ? row_q : (row_q == V_LAST) ? '0 : row_q + 1'b1;
  end
  // counter registers, published directly as the coordinate stream
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      col_q <= '0;
      row_q <= '0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
    end
  // raw decodes, cycle-aligned with the counters
  always_comb begin
    vis_raw = (col_q < H_VIS) && (row_q < V_VIS);
    hs_raw = (col_q >= HS_START && col_q < HS_END) ? SYNC_POL : ~SYNC_POL;
    vs_raw = (row_q >= VS_START && row_q < VS_END) ? SYNC_POL : ~SYNC_POL;
  end
  sync_delay_line #(
    .W(3),
    .D(SYNC_DELAY),
    .RST({~SYNC_POL, ~SYNC_POL, 1'b0})
  ) u_dly (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .d_i({hs_raw, vs_raw, vis_raw}),
    .q_o(dly_q)
  );
  assign vga.display_col = col_q;
  assign vga.display_row = row_q;
  assign vga.visible = vis_raw;
  assign vga.frame_start = (col_q == '0) && (row_q == '0);
  assign vga.line_start = col_q == '0;
  assign vga.vga_hs = dly_q[2];
  assign vga.vga_vs = dly_q[1];
  assign vga.vga_de = dly_q[0];
endmodule
